// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared constants for the FND (7-segment) scan controller.
//   COM_OFF / FONT_OFF : all commons and all segments dark (active-low).
//   SEG_BLANK          : seven segments dark, used for leading-zero blanking.
//   HEX_FONT           : active-low {dp,g,f,e,d,c,b,a} code per hex value,
//                        dp bit dark. Only the low seven bits are used.
//   lead_zero()        : true when digit k and every digit above it are zero.
package fnd_scan_ctrl_pkg;

  localparam logic [3:0] COM_OFF   = 4'hF;
  localparam logic [7:0] FONT_OFF  = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] HEX_FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Digit 0 is never treated as a leading zero so a value of 0 still shows "0".
  function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] k);
    case (k)
      2'd3:    return (d[15:12] == 4'h0);
      2'd2:    return (d[15:8]  == 8'h00);
      2'd1:    return (d[15:4]  == 12'h000);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_bcd2seg.sv
// Hex nibble to active-low seven-segment decoder (combinational).
//   nib : hex value 0..F
//   seg : segments {g,f,e,d,c,b,a}, active-low
module fnd_scan_ctrl_bcd2seg
  import fnd_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = HEX_FONT[nib];
    seg  = code[6:0];
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed 7-segment display scan controller.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   digits_in : four hex nibbles, [3:0] = digit0 (rightmost)
//   dp_in     : decimal point per digit, 1 = lit
//   load      : one-cycle strobe capturing digits_in / dp_in
//   lz_en     : leading-zero blanking enable
//   enable    : display on/off
//   fnd_com   : digit commons, active-low, one-hot-low while a digit is lit
//   fnd_font  : segments {dp,g,f,e,d,c,b,a}, active-low
// Each digit owns SCAN_DIV cycles; the first BLANK_CYC of them are dark to
// avoid ghosting while the commons switch. Outputs are registered.
module fnd_scan_ctrl
  import fnd_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lz_en,
  input  logic        enable,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_font
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [15:0]      disp_reg;
  logic [3:0]       dp_reg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic             show_p0;
  logic [3:0]       nib_p0;
  logic [6:0]       seg_p0;
  logic [3:0]       com_p0;
  logic [7:0]       font_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_reg <= '0;
      dp_reg   <= '0;
    end else if (load) begin
      disp_reg <= digits_in;
      dp_reg   <= dp_in;
    end
  end

  // Prescaler and digit index run regardless of enable so that switching the
  // display back on resumes exactly where the scan has got to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stage p0: select and decode the active digit
  always_comb begin
    nib_p0 = disp_reg[{idx, 2'b00} +: 4];
  end

  fnd_scan_ctrl_bcd2seg u_bcd2seg (
    .nib (nib_p0),
    .seg (seg_p0)
  );

  always_comb begin
    com_p0  = COM_OFF;
    font_p0 = FONT_OFF;
    show_p0 = enable && (cnt >= CNT_BLANK);
    if (show_p0) begin
      com_p0       = ~(4'b0001 << idx);
      font_p0[7]   = ~dp_reg[idx];
      font_p0[6:0] = (lz_en && lead_zero(disp_reg, idx)) ? SEG_BLANK : seg_p0;
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_com  <= COM_OFF;
      fnd_font <= FONT_OFF;
    end else begin
      fnd_com  <= com_p0;
      fnd_font <= font_p0;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1.
// A reference model counts edges since reset release and derives the digit
// slot and position by division, pushing the expected output of every edge
// into a queue; a negedge monitor pops and compares.
module tb_fnd_scan_ctrl;

  localparam int SD = 4;
  localparam int BC = 1;

  logic        clk;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic        enable;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_font;

  fnd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .load      (load),
    .lz_en     (lz_en),
    .enable    (enable),
    .fnd_com   (fnd_com),
    .fnd_font  (fnd_font)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [3:0] ac, input logic [7:0] af,
                     input logic [3:0] ec, input logic [7:0] ef);
    n_checks++;
    if (ac !== ec || af !== ef) begin
      n_err++;
      $display("FAIL %s @%0t: got com=%h font=%h, expected com=%h font=%h",
               name, $time, ac, af, ec, ef);
    end
  endtask

  // Segment codes written straight from the hex font table, dp dark.
  logic [7:0] font_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // ---------------- reference model ----------------
  int          m_t;      // edges since reset release
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic [11:0] exp_q[$];

  function automatic logic [11:0] expect_out(input int t, input logic [15:0] d,
                                             input logic [3:0] dp, input logic en,
                                             input logic lz);
    int pos, id;
    logic [3:0] com;
    logic [7:0] font;
    pos = t % SD;
    id  = (t / SD) % 4;
    if (!en || pos < BC) return {4'hF, 8'hFF};
    com  = 4'hF;
    com[id] = 1'b0;
    font = font_tab[(d >> (4 * id)) & 16'hF];
    if (lz && id > 0 && (d >> (4 * id)) == 16'h0) font[6:0] = 7'h7F;
    font[7] = ~dp[id];
    return {com, font};
  endfunction

  initial begin
    m_t = 0; m_disp = '0; m_dp = '0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_t = 0; m_disp = '0; m_dp = '0;
    end else begin
      exp_q.push_back(expect_out(m_t, m_disp, m_dp, enable, lz_en));
      m_t = m_t + 1;
      if (load) begin
        m_disp = digits_in;
        m_dp   = dp_in;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [11:0] e;
    if (reset) begin
      chk("reset_off", fnd_com, fnd_font, 4'hF, 8'hFF);
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      chk("idle_off", fnd_com, fnd_font, 4'hF, 8'hFF);
    end else begin
      e = exp_q.pop_front();
      chk("scan", fnd_com, fnd_font, e[11:8], e[7:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Wait until the next edge will see slot index want_idx (-1 = any) at want_pos.
  task automatic wait_slot(input int want_idx, input int want_pos);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_t % SD == want_pos && (want_idx < 0 || (m_t / SD) % 4 == want_idx))
        found = 1;
      else
        step(1);
    end
    if (!found) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_slot: slot %0d pos %0d not reached, required within 64 cycles",
               want_idx, want_pos);
    end
  endtask

  logic [3:0] seq_com  [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [7:0] seq_font [16] = '{8'hFF, 8'h99, 8'h99, 8'h99, 8'hFF, 8'hB0, 8'hB0, 8'hB0,
                                8'hFF, 8'hA4, 8'hA4, 8'hA4, 8'hFF, 8'hF9, 8'hF9, 8'hF9};
  logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  initial begin
    reset = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; lz_en = 1'b0; enable = 1'b0;
    step(2);

    // Run briefly, then assert reset between edges while a digit is lit.
    reset = 1'b0; enable = 1'b1; load = 1'b1; digits_in = 16'h1234;
    step(1);
    load = 1'b0;
    step(2);
    reset = 1'b1;
    #1;
    chk("rst_async", fnd_com, fnd_font, 4'hF, 8'hFF);
    step(2);

    // Fixed scan sequence after release.
    reset = 1'b0; load = 1'b1; digits_in = 16'h1234; dp_in = 4'h0;
    step(1);
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("scan_seq", fnd_com, fnd_font, seq_com[i], seq_font[i]);
    end

    // Leading-zero blanking.
    step(1);
    lz_en = 1'b1; load = 1'b1; digits_in = 16'h0050;
    step(1);
    load = 1'b0;
    step(18);
    load = 1'b1; digits_in = 16'h0000;
    step(1);
    load = 1'b0;
    step(18);

    // Decimal point on digit2.
    lz_en = 1'b0; load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100;
    step(1);
    load = 1'b0;
    step(18);

    // Load in the middle of digit1's slot.
    wait_slot(1, 2);
    load = 1'b1; digits_in = 16'hABCD; dp_in = 4'h0;
    step(1);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("load_mid", fnd_com, fnd_font, 4'hD, 8'hC6);

    // Load on a slot-boundary edge.
    step(1);
    wait_slot(-1, SD - 1);
    load = 1'b1; digits_in = 16'h9876;
    step(1);
    load = 1'b0;
    step(8);

    // Display off for 6 cycles, scan keeps running underneath.
    enable = 1'b0;
    step(6);
    enable = 1'b1;
    step(12);

    // Reset while digit2 is lit; scan restarts at digit0 with cleared registers.
    wait_slot(2, 2);
    reset = 1'b1;
    #1;
    chk("rst_mid", fnd_com, fnd_font, 4'hF, 8'hFF);
    step(2);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("restart_d0", fnd_com, fnd_font, 4'hE, 8'hC0);
    step(1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      load      = ($urandom_range(0, 7) == 0);
      digits_in = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_in     = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en  = ~lz_en;
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        step(2);
        reset = 1'b0;
      end
      step(1);
    end
    load = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz), legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYC, default 1000, anti-ghost blanking cycles at the start of each slot, legal range 0 .. SCAN_DIV-1.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port digits_in, input, 16, four hex nibbles; [3:0] is digit0 (rightmost) and [15:12] is digit3.
REQ-006 SHALL have port dp_in, input, 4, decimal-point request per digit, 1 = lit.
REQ-007 SHALL have port load, input, 1, single-cycle strobe that captures digits_in and dp_in.
REQ-008 SHALL have port lz_en, input, 1, leading-zero blanking enable (level).
REQ-009 SHALL have port enable, input, 1, display on/off (level).
REQ-010 SHALL have port fnd_com, output, 4, digit commons, active-low, one-hot-low when a digit is active.
REQ-011 SHALL have port fnd_font, output, 8, segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-012 SHALL hold a 16-bit display register and a 4-bit dp register, loaded from digits_in/dp_in on any clock edge with load=1 and held otherwise.
REQ-013 SHALL run a prescaler cnt counting 0..SCAN_DIV-1 and wrapping to 0, free-running regardless of enable and load.
REQ-014 SHALL advance a 2-bit digit index idx (0->1->2->3->0) on each edge where cnt==SCAN_DIV-1.
REQ-015 SHALL register both outputs, each computed from the cnt/idx/register values present before the edge (1-cycle latency).
REQ-016 SHALL drive fnd_com=4'hF and fnd_font=8'hFF whenever enable=0 or cnt<BLANK_CYC.
REQ-017 SHALL otherwise drive fnd_com with bit idx low and all other bits high.
REQ-018 SHALL drive fnd_font[6:0] from the standard hex code of nibble idx: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E (low 7 bits).
REQ-019 SHALL drive fnd_font[7] = ~dp_reg[idx].
REQ-020 SHALL, when lz_en=1, blank the segments of digit k (k=3,2,1) when nibbles k..3 are all zero, forcing fnd_font[6:0]=7'h7F; digit0 is never blanked, and dp remains governed by REQ-019.
REQ-021 SHALL, when load and a slot boundary occur on the same edge, use the new register contents for the first output of the new slot.
REQ-022 SHALL, when enable returns to 1, resume at the current idx/cnt with no restart.

Reset
REQ-023 SHALL, while reset=1 and with no clock edge needed, force fnd_com=4'hF, fnd_font=8'hFF, cnt=0, idx=0, and display/dp registers to 0.
REQ-024 SHALL begin scanning at digit0, cnt=0, on the first edge after reset is released; reset mid-slot aborts that slot.

Structure
REQ-025 SHALL place the hex-to-segment code constants and the blank constants (COM_OFF=4'hF, FONT_OFF=8'hFF) in a shared package.
REQ-026 SHALL instantiate the existing BCD2SEG decoder as its single sub-module, fed by the idx-selected nibble.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-027 SHALL cover reset: assert reset between edges -> fnd_com=F and fnd_font=FF immediately; after release, load 16'h1234 with enable=1.
REQ-028 SHALL cover the scan order after reset: per slot 1 cycle F/FF then 3 cycles each of (E,99), (D,B0), (B,A4), (7,F9), repeating every 16 cycles.
REQ-029 SHALL cover leading zeros: 16'h0050 with lz_en=1 -> digit3/digit2 font FF, digit1 92, digit0 C0; 16'h0000 -> only digit0 shows C0.
REQ-030 SHALL cover the decimal point: 16'h1234 with dp_in=4'b0100 -> digit2 font 24, other digits unchanged.
REQ-031 SHALL cover load timing: load 16'hABCD mid-slot of digit1 -> next output C6 on com D; load on a boundary edge -> the new slot shows the new value.
REQ-032 SHALL cover enable and reset during scanning: enable=0 for 6 cycles -> outputs F/FF while idx keeps advancing, and re-enable shows the idx reached; reset during digit2 -> outputs off asynchronously, and after release the scan restarts at digit0.
